// File: rtl/alu_cmd_loader_pkg.sv
// Shared definitions for the ALU command loader: FSM encoding and frame format.
package alu_cmd_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_OPA   = 2'd2,
        ST_ISSUE = 2'd3
    } state_e;

    localparam logic [3:0] HDR_MARK   = 4'hA;
    localparam logic [3:0] MAX_OPCODE = 4'hC;
    localparam int         FRAME_LEN  = 3;

    function automatic logic hdr_valid(input logic [7:0] b);
        return (b[7:4] == HDR_MARK) && (b[3:0] <= MAX_OPCODE);
    endfunction

endpackage

// File: rtl/alu_cmd_loader_if.sv
// Byte stream in, registered ALU command out, plus status.
interface alu_cmd_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [3:0] sel;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       frame_err;
    logic [7:0] cmd_count;

    modport slave (
        input  byte_in, byte_valid, cmd_ready,
        output byte_ready, sel, in1, in2, cmd_valid, frame_err, cmd_count
    );

    modport master (
        output byte_in, byte_valid, cmd_ready,
        input  byte_ready, sel, in1, in2, cmd_valid, frame_err, cmd_count
    );
endinterface

// File: rtl/alu_cmd_timeout.sv
// Inter-byte idle counter; expired fires in the cycle the count would reach the limit.
module alu_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // clear has priority so an accepted byte always beats the timeout
    assign expired = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) cnt_d = 8'd0;
        else if (enable)      cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/alu_cmd_loader.sv
// Assembles 3-byte frames (header, A, B) into a registered ALU command with
// header validation and inter-byte timeout.
module alu_cmd_loader
    import alu_cmd_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic           clk,
    input logic           rst_n,
    alu_cmd_loader_if.slave bus
);

    state_e     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [7:0] in1_q, in1_d;
    logic [7:0] in2_q, in2_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] cmd_count_q, cmd_count_d;

    logic byte_ready;
    logic accept;
    logic in_frame;
    logic expired;

    assign byte_ready = (state_q != ST_ISSUE);
    assign accept     = bus.byte_valid && byte_ready;
    assign in_frame   = (state_q == ST_HDR) || (state_q == ST_OPA);

    alu_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (in_frame && !accept),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        cmd_valid_d = cmd_valid_q;
        frame_err_d = 1'b0;
        cmd_count_d = cmd_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_valid(bus.byte_in)) begin
                        sel_d   = bus.byte_in[3:0];
                        state_d = ST_HDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (accept) begin
                    in1_d   = bus.byte_in;
                    state_d = ST_OPA;
                end else if (expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_OPA: begin
                if (accept) begin
                    in2_d       = bus.byte_in;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // command is held until the ALU stage takes it
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    cmd_count_d = cmd_count_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 4'd0;
            in1_q       <= 8'd0;
            in2_q       <= 8'd0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.sel        = sel_q;
    assign bus.in1        = in1_q;
    assign bus.in2        = in2_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.cmd_count  = cmd_count_q;

endmodule
